mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum WAIT cycles without dmem_ack before an access is aborted (legal 2..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports mem_write_in, mem_read_in, mem_to_reg_in, reg_write_in  input  1 each  control bits from the EX/MEM register.
REQ-005 SHALL have port alu_in  input  32  ALU result, used as byte address for memory ops.
REQ-006 SHALL have port rd2_in  input  32  store data.
REQ-007 SHALL have port wn_in  input  5  destination register number.
REQ-008 SHALL have ports dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32  data-memory request bus, all registered.
REQ-009 SHALL have ports dmem_rdata in 32, dmem_ack in 1  data-memory response; ack is a single-cycle pulse.
REQ-010 SHALL have port stall  output  1  combinational hold request to EX/MEM and upstream stages.
REQ-011 SHALL have ports reg_write_out, mem_to_reg_out out 1; rdata_out out 32; alu_out out 32; wn_out out 5  registered MEM/WB outputs.
REQ-012 SHALL have port bus_err  output  1  sticky error flag.

Function
REQ-013 SHALL implement FSM states IDLE and WAIT.
- An access is pending when mem_read_in|mem_write_in is 1.
- If both are 1, the access is treated as a write.
REQ-014 IDLE, no access pending: each edge SHALL copy reg_write_in, mem_to_reg_in, alu_in and wn_in to the outputs, with rdata_out=0 and stall=0.
REQ-015 IDLE, aligned access pending (alu_in[1:0]==0): stall SHALL be 1 combinationally; at the edge the block SHALL:
- latch dmem_addr=alu_in, dmem_wdata=rd2_in, dmem_we=mem_write_in;
- set dmem_req=1 and move to WAIT.
REQ-016 WAIT: dmem_req and the address/data/we signals SHALL hold stable; stall SHALL be 1 until the cycle dmem_ack=1, in which stall SHALL be 0.
REQ-017 On the WAIT edge with dmem_ack=1 the block SHALL:
- drive reg_write_out/mem_to_reg_out/alu_out/wn_out from the held inputs;
- drive rdata_out=dmem_rdata for a read, or 0 for a write;
- drop dmem_req and return to IDLE.
REQ-018 Any edge on which the block is stalling SHALL emit a bubble: reg_write_out=0, mem_to_reg_out=0, rdata_out=0, alu_out=0, wn_out=0.
REQ-019 Minimum memory-op latency SHALL be 2 cycles (present cycle plus one WAIT cycle with ack); non-memory ops SHALL have 1 cycle of latency.
REQ-020 A WAIT cycle counter SHALL clear on entry to WAIT.
- If the counter reaches TIMEOUT-1 with dmem_ack=0, the block SHALL set bus_err=1, drop dmem_req, and complete the instruction with reg_write_out=0.
- The block SHALL then return to IDLE with stall=0 in that cycle.
REQ-021 For a misaligned access (alu_in[1:0]!=0) the block SHALL:
- issue no request and not stall;
- set bus_err=1 and pass the instruction with reg_write_out=0 and mem_to_reg_out=0.
REQ-022 dmem_ack in IDLE SHALL be ignored; ack coincident with the timeout cycle SHALL count as success (no bus_err).
REQ-023 bus_err SHALL remain 1 until rst.

Reset
REQ-024 rst on an edge SHALL force state IDLE, counter 0, bus_err 0, dmem_req/dmem_we 0, dmem_addr/dmem_wdata 0, and all MEM/WB outputs 0, regardless of state (including mid-WAIT).
REQ-025 During the rst cycle stall SHALL be 0.

Verification
REQ-026 ALU op: reg_write_in=1, alu_in=0x0000_0055, wn_in=7 -> next edge reg_write_out=1, alu_out=0x55, wn_out=7, stall never 1.
REQ-027 Load: mem_read_in=1, alu_in=0x100, ack 3 cycles after req with dmem_rdata=0xDEADBEEF -> stall high 4 cycles, bubbles meanwhile, then rdata_out=0xDEADBEEF, mem_to_reg_out=1.
REQ-028 Store: mem_write_in=1, alu_in=0x40, rd2_in=0x1234 -> dmem_we=1, dmem_addr=0x40, dmem_wdata=0x1234 held until ack; rdata_out=0, no bus_err.
REQ-029 Misaligned load alu_in=0x102 -> dmem_req stays 0, bus_err=1, reg_write_out=0; bus_err remains 1 after 10 further ALU ops.
REQ-030 Timeout: load with no ack, TIMEOUT=16 -> stall drops in the 16th WAIT cycle, bus_err=1, dmem_req=0, reg_write_out=0; rst mid-WAIT instead -> all outputs 0 the following cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-memory access per load/store, holds the
// pipeline while waiting for ack, and aborts with a sticky bus_err on timeout or misalignment.
module mem_access_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_write_in,
   input  logic        mem_read_in,
   input  logic        mem_to_reg_in,
   input  logic        reg_write_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] rd2_in,
   input  logic [4:0]  wn_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall,
   output logic        reg_write_out,
   output logic        mem_to_reg_out,
   output logic [31:0] rdata_out,
   output logic [31:0] alu_out,
   output logic [4:0]  wn_out,
   output logic        bus_err
);

   // Handshake: dmem_req rises with a stable request bus and stays high until
   // the single-cycle dmem_ack pulse (or timeout); stall holds upstream meanwhile.
   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t     state_q;
   logic [7:0] cnt_q;
   logic       rw_h_q;
   logic       mtr_h_q;
   logic [4:0] wn_h_q;

   logic pending;
   logic aligned;
   logic timeout_hit;

   assign pending     = mem_read_in | mem_write_in;
   assign aligned     = (alu_in[1:0] == 2'b00);
   assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

   // Stall releases in the ack cycle and in the timeout cycle so the
   // instruction completes on that edge.
   assign stall = !rst &&
                  (((state_q == S_IDLE) && pending && aligned) ||
                   ((state_q == S_WAIT) && !dmem_ack && !timeout_hit));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= 8'd0;
         rw_h_q         <= 1'b0;
         mtr_h_q        <= 1'b0;
         wn_h_q         <= 5'd0;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= 32'd0;
         dmem_wdata     <= 32'd0;
         reg_write_out  <= 1'b0;
         mem_to_reg_out <= 1'b0;
         rdata_out      <= 32'd0;
         alu_out        <= 32'd0;
         wn_out         <= 5'd0;
         bus_err        <= 1'b0;
      end else begin
         reg_write_out  <= 1'b0;
         mem_to_reg_out <= 1'b0;
         rdata_out      <= 32'd0;
         alu_out        <= 32'd0;
         wn_out         <= 5'd0;
         case (state_q)
            S_IDLE: begin
               if (!pending) begin
                  reg_write_out  <= reg_write_in;
                  mem_to_reg_out <= mem_to_reg_in;
                  alu_out        <= alu_in;
                  wn_out         <= wn_in;
               end else if (!aligned) begin
                  bus_err <= 1'b1;
                  alu_out <= alu_in;
                  wn_out  <= wn_in;
               end else begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write_in;
                  dmem_addr  <= alu_in;
                  dmem_wdata <= rd2_in;
                  rw_h_q     <= reg_write_in;
                  mtr_h_q    <= mem_to_reg_in;
                  wn_h_q     <= wn_in;
                  cnt_q      <= 8'd0;
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               // dmem_addr doubles as the held ALU result for the completing instruction.
               if (dmem_ack) begin
                  reg_write_out  <= rw_h_q;
                  mem_to_reg_out <= mtr_h_q;
                  rdata_out      <= dmem_we ? 32'd0 : dmem_rdata;
                  alu_out        <= dmem_addr;
                  wn_out         <= wn_h_q;
                  dmem_req       <= 1'b0;
                  dmem_we        <= 1'b0;
                  state_q        <= S_IDLE;
               end else if (timeout_hit) begin
                  bus_err        <= 1'b1;
                  mem_to_reg_out <= mtr_h_q;
                  alu_out        <= dmem_addr;
                  wn_out         <= wn_h_q;
                  dmem_req       <= 1'b0;
                  dmem_we        <= 1'b0;
                  state_q        <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table for pass-through ops plus
// hand-written load/store/timeout/reset sequences, scoreboarded via exp_q.
module tb_mem_access_stage;

   localparam int W = 73;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_write_in, mem_read_in, mem_to_reg_in, reg_write_in;
   logic [31:0] alu_in, rd2_in;
   logic [4:0]  wn_in;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        stall;
   logic        reg_write_out, mem_to_reg_out;
   logic [31:0] rdata_out, alu_out;
   logic [4:0]  wn_out;
   logic        bus_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] act;

   mem_access_stage #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
      .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
      .alu_in(alu_in), .rd2_in(rd2_in), .wn_in(wn_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall(stall), .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
      .rdata_out(rdata_out), .alu_out(alu_out), .wn_out(wn_out), .bus_err(bus_err)
   );

   // clock / reset
   always #5 clk = ~clk;

   assign act = {reg_write_out, mem_to_reg_out, rdata_out, alu_out, wn_out, bus_err, dmem_req};

   function automatic logic [W-1:0] pk(input logic rw, input logic mtr, input logic [31:0] rd,
                                       input logic [31:0] alu, input logic [4:0] wn,
                                       input logic be, input logic rq);
      return {rw, mtr, rd, alu, wn, be, rq};
   endfunction

   task automatic check(input string name, input logic [W-1:0] a, input logic [W-1:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   task automatic chk_bus(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd);
      check(name, W'({dmem_we, dmem_addr, dmem_wdata}), W'({we, addr, wd}));
   endtask

   // driver: one clock with given inputs; stall checked before the edge,
   // registered outputs checked against the scoreboard after it
   task automatic cyc(input logic mw, input logic mr, input logic mtr, input logic rw,
                      input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wn,
                      input logic ack, input logic [31:0] rdat,
                      input logic e_stall, input logic [W-1:0] e_out, input string name);
      @(negedge clk);
      rst = 1'b0;
      mem_write_in = mw; mem_read_in = mr; mem_to_reg_in = mtr; reg_write_in = rw;
      alu_in = alu; rd2_in = rd2; wn_in = wn; dmem_ack = ack; dmem_rdata = rdat;
      exp_q.push_back(e_out);
      #1;
      check({name, "_stall"}, W'(stall), W'(e_stall));
      @(posedge clk);
      #1;
      check(name, act, exp_q.pop_front());
   endtask

   task automatic rst_cycle(input string name);
      @(negedge clk);
      rst = 1'b1;
      mem_read_in = 1'b1; mem_write_in = 1'b0; alu_in = 32'h100; dmem_ack = 1'b0;
      #1;
      check({name, "_stall"}, W'(stall), W'(1'b0));
      @(posedge clk);
      #1;
      check(name, act, pk(0, 0, 0, 0, 0, 0, 0));
      chk_bus({name, "_bus"}, 0, 0, 0);
   endtask

   typedef struct {
      logic rw; logic mtr; logic [31:0] alu; logic [4:0] wn;
      logic e_rw; logic e_mtr; logic [31:0] e_alu; logic [4:0] e_wn;
   } vec_t;
   vec_t tbl[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 1'b0, 32'h0000_0055, 5'd7,  1'b1, 1'b0, 32'h0000_0055, 5'd7};
      tbl[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'd31};
      tbl[2] = '{1'b1, 1'b1, 32'h0000_0003, 5'd1,  1'b1, 1'b1, 32'h0000_0003, 5'd1};
      tbl[3] = '{1'b0, 1'b1, 32'h8000_0002, 5'd0,  1'b0, 1'b1, 32'h8000_0002, 5'd0};
      tbl[4] = '{1'b1, 1'b0, 32'h0000_0000, 5'd16, 1'b1, 1'b0, 32'h0000_0000, 5'd16};
      tbl[5] = '{1'b1, 1'b1, 32'h1234_5679, 5'd30, 1'b1, 1'b1, 32'h1234_5679, 5'd30};

      mem_write_in = 0; mem_read_in = 0; mem_to_reg_in = 0; reg_write_in = 0;
      alu_in = 0; rd2_in = 0; wn_in = 0; dmem_ack = 0; dmem_rdata = 0; rst = 1;
      rst_cycle("reset0");
      rst_cycle("reset1");

      for (int i = 0; i < 6; i++)
         cyc(0, 0, tbl[i].mtr, tbl[i].rw, tbl[i].alu, 32'h0, tbl[i].wn, 0, 32'h0, 0,
             pk(tbl[i].e_rw, tbl[i].e_mtr, 0, tbl[i].e_alu, tbl[i].e_wn, 0, 0), "alu_vec");

      // ack while idle must not leak into rdata_out
      cyc(0, 0, 0, 1, 32'h9, 0, 2, 1, 32'hCAFE_F00D, 0, pk(1, 0, 0, 32'h9, 2, 0, 0), "ack_idle");

      // load, ack three cycles after request
      cyc(0, 1, 1, 1, 32'h100, 0, 3, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 1), "ld_issue");
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 1, 1, 32'h100, 0, 3, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 1), "ld_wait");
         chk_bus("ld_bus", 0, 32'h100, 0);
      end
      cyc(0, 1, 1, 1, 32'h100, 0, 3, 1, 32'hDEAD_BEEF, 0,
          pk(1, 1, 32'hDEAD_BEEF, 32'h100, 3, 0, 0), "ld_done");

      // store
      cyc(1, 0, 0, 0, 32'h40, 32'h1234, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 1), "st_issue");
      chk_bus("st_bus0", 1, 32'h40, 32'h1234);
      cyc(1, 0, 0, 0, 32'h40, 32'h1234, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 1), "st_wait");
      chk_bus("st_bus1", 1, 32'h40, 32'h1234);
      cyc(1, 0, 0, 0, 32'h40, 32'h1234, 0, 1, 32'hFFFF_0000, 0,
          pk(0, 0, 0, 32'h40, 0, 0, 0), "st_done");

      // read+write together is a write; minimum two-cycle latency
      cyc(1, 1, 1, 1, 32'h80, 32'hAA, 4, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 1), "rw_issue");
      chk_bus("rw_bus", 1, 32'h80, 32'hAA);
      cyc(1, 1, 1, 1, 32'h80, 32'hAA, 4, 1, 32'h5555, 0, pk(1, 1, 0, 32'h80, 4, 0, 0), "rw_done");

      // ack arriving in the timeout cycle is a success
      cyc(0, 1, 1, 1, 32'h200, 0, 5, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 1), "late_issue");
      for (int i = 0; i < 15; i++)
         cyc(0, 1, 1, 1, 32'h200, 0, 5, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 1), "late_wait");
      cyc(0, 1, 1, 1, 32'h200, 0, 5, 1, 32'h1234_5678, 0,
          pk(1, 1, 32'h1234_5678, 32'h200, 5, 0, 0), "late_done");

      // timeout: stall drops in the 16th WAIT cycle
      cyc(0, 1, 0, 1, 32'h300, 0, 6, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 1), "to_issue");
      for (int i = 0; i < 15; i++)
         cyc(0, 1, 0, 1, 32'h300, 0, 6, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 1), "to_wait");
      cyc(0, 1, 0, 1, 32'h300, 0, 6, 0, 0, 0, pk(0, 0, 0, 32'h300, 6, 1, 0), "to_done");
      cyc(0, 0, 0, 1, 32'h11, 0, 8, 0, 0, 0, pk(1, 0, 0, 32'h11, 8, 1, 0), "to_after");

      // reset in the middle of WAIT clears everything, including bus_err
      cyc(0, 1, 1, 1, 32'h400, 0, 2, 0, 0, 1, pk(0, 0, 0, 0, 0, 1, 1), "rw_mid_issue");
      cyc(0, 1, 1, 1, 32'h400, 0, 2, 0, 0, 1, pk(0, 0, 0, 0, 0, 1, 1), "rw_mid_wait");
      rst_cycle("reset_mid");
      cyc(0, 0, 0, 1, 32'h22, 0, 9, 0, 0, 0, pk(1, 0, 0, 32'h22, 9, 0, 0), "post_rst");

      // misaligned load, then bus_err must stay set
      cyc(0, 1, 1, 1, 32'h102, 0, 9, 0, 0, 0, pk(0, 0, 0, 32'h102, 9, 1, 0), "mis_ld");
      for (int i = 0; i < 10; i++) begin
         logic [31:0] a;
         logic [4:0]  w;
         a = $urandom_range(0, 32'hFFFF);
         w = 5'($urandom_range(0, 31));
         cyc(0, 0, 0, 1, a, 0, w, 0, 0, 0, pk(1, 0, 0, a, w, 1, 0), "sticky_err");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
